// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: bus visit codes, access sizes, FSM states.
package mem_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 17;
  localparam int unsigned DEF_LEN        = 32;
  localparam int unsigned DEF_BYTE_SIZE  = 8;
  localparam int unsigned CNT_W          = 3;

  // Memory-bus visit signal
  typedef enum logic [1:0] {
    MEM_IDLE      = 2'b00,
    MEM_READ_INST = 2'b01,
    MEM_READ_DATA = 2'b10,
    MEM_WRITE     = 2'b11
  } vis_e;

  // Load/store access size codes
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // Number of byte transactions for a data access; 11 behaves as a word
  function automatic logic [CNT_W-1:0] size_to_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return CNT_W'(1);
      SIZE_HALF: return CNT_W'(2);
      default:   return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Fixed-priority request select: data port wins over instruction port.
module mem_arb
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  output logic                  grant_c,
  output vis_e                  op_c,
  output logic [ADDR_WIDTH-1:0] base_c,
  output logic [CNT_W-1:0]      count_c
);

  // Pick the winning request and describe the transaction it needs
  always_comb begin
    grant_c = 1'b0;
    op_c    = MEM_IDLE;
    base_c  = '0;
    count_c = '0;
    if (data_req) begin
      grant_c = 1'b1;
      op_c    = data_we ? MEM_WRITE : MEM_READ_DATA;
      base_c  = data_addr;
      count_c = size_to_count(data_size);
    end else if (inst_req) begin
      grant_c = 1'b1;
      op_c    = MEM_READ_INST;
      base_c  = inst_addr;
      count_c = CNT_W'(4);
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: serialises CPU byte/half/word accesses onto a byte-wide memory bus.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LEN        = DEF_LEN,
  parameter int unsigned BYTE_SIZE  = DEF_BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [LEN-1:0]        inst_data,
  output logic                  inst_done,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [LEN-1:0]        data_wdata,
  output logic [LEN-1:0]        data_rdata,
  output logic                  data_done,
  output logic                  busy,
  input  logic [BYTE_SIZE-1:0]  mem_data,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [1:0]            mem_vis_signal,
  output logic [BYTE_SIZE-1:0]  writen_data
);

  state_e                state_q, state_d;
  vis_e                  op_q, op_d, vis_q, vis_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, vis_addr_q, vis_addr_d;
  logic [CNT_W-1:0]      n_q, n_d, cnt_q, cnt_d;
  logic [LEN-1:0]        wdata_q, wdata_d, acc_q, acc_d;
  logic [LEN-1:0]        inst_data_q, inst_data_d, rdata_q, rdata_d;
  logic [BYTE_SIZE-1:0]  wr_q, wr_d;
  logic                  inst_done_q, inst_done_d, data_done_q, data_done_d;
  logic                  busy_q, busy_d;

  logic                  grant_c;
  vis_e                  op_c;
  logic [ADDR_WIDTH-1:0] base_c;
  logic [CNT_W-1:0]      count_c;
  logic [CNT_W-1:0]      byte_idx;
  logic [LEN-1:0]        acc_new;

  mem_arb #(.ADDR_WIDTH(ADDR_WIDTH)) u_arb (
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_size (data_size),
    .data_addr (data_addr),
    .grant_c   (grant_c),
    .op_c      (op_c),
    .base_c    (base_c),
    .count_c   (count_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= MEM_IDLE;
      vis_q       <= MEM_IDLE;
      base_q      <= '0;
      vis_addr_q  <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      inst_data_q <= '0;
      rdata_q     <= '0;
      wr_q        <= '0;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      vis_q       <= vis_d;
      base_q      <= base_d;
      vis_addr_q  <= vis_addr_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      acc_q       <= acc_d;
      inst_data_q <= inst_data_d;
      rdata_q     <= rdata_d;
      wr_q        <= wr_d;
      inst_done_q <= inst_done_d;
      data_done_q <= data_done_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: accept, issue bytes base..base+n-1, capture read bytes two edges after issue
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    vis_d       = MEM_IDLE;
    base_d      = base_q;
    vis_addr_d  = vis_addr_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    inst_data_d = inst_data_q;
    rdata_d     = rdata_q;
    wr_d        = wr_q;
    inst_done_d = 1'b0;
    data_done_d = 1'b0;
    byte_idx    = CNT_W'(cnt_q - CNT_W'(2));
    acc_new     = acc_q;

    case (state_q)
      S_IDLE: begin
        if (grant_c) begin
          op_d       = op_c;
          base_d     = base_c;
          n_d        = count_c;
          wdata_d    = data_wdata;
          acc_d      = '0;
          vis_d      = op_c;
          vis_addr_d = base_c;
          wr_d       = data_wdata[BYTE_SIZE-1:0];
          cnt_d      = CNT_W'(1);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q < n_q) begin
          vis_d      = op_q;
          vis_addr_d = base_q + ADDR_WIDTH'(cnt_q);
          wr_d       = wdata_q[BYTE_SIZE*int'(cnt_q) +: BYTE_SIZE];
        end else if (op_q == MEM_WRITE) begin
          state_d     = S_DONE;
          data_done_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read byte k arrives at edge k+2; the last one completes the transaction
    if ((state_q == S_ISSUE || state_q == S_DRAIN) && op_q != MEM_WRITE &&
        cnt_q >= CNT_W'(2)) begin
      acc_new[BYTE_SIZE*int'(byte_idx) +: BYTE_SIZE] = mem_data;
      acc_d = acc_new;
      if (cnt_q == CNT_W'(n_q + CNT_W'(1))) begin
        state_d = S_DONE;
        if (op_q == MEM_READ_INST) begin
          inst_data_d = acc_new;
          inst_done_d = 1'b1;
        end else begin
          rdata_d     = acc_new;
          data_done_d = 1'b1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign inst_data      = inst_data_q;
  assign inst_done      = inst_done_q;
  assign data_rdata     = rdata_q;
  assign data_done      = data_done_q;
  assign busy           = busy_q;
  assign mem_vis_addr   = vis_addr_q;
  assign mem_vis_signal = vis_q;
  assign writen_data    = wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte memory model, bus monitor and a reference byte array.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req = 1'b0;
  logic [16:0] inst_addr = '0;
  logic [31:0] inst_data;
  logic        inst_done;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [1:0]  data_size = '0;
  logic [16:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        busy;
  logic [7:0]  mem_data = '0;
  logic [16:0] mem_vis_addr;
  logic [1:0]  mem_vis_signal;
  logic [7:0]  writen_data;

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data), .inst_done(inst_done),
    .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done), .busy(busy),
    .mem_data(mem_data), .mem_vis_addr(mem_vis_addr), .mem_vis_signal(mem_vis_signal),
    .writen_data(writen_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] addr;
    logic [1:0]  sig;
    logic [7:0]  wd;
  } visit_t;

  logic [7:0] mem     [131072];
  logic [7:0] ref_mem [131072];
  visit_t     exp_q[$];
  visit_t     mon_v;
  bit         init_done = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte memory: registered read, write on the edge after the bus is driven
  initial begin
    wait (init_done);
    for (int i = 0; i < 131072; i++) mem[i] = ref_mem[i];
    forever begin
      @(posedge clk);
      if (mem_vis_signal == 2'b11) mem[mem_vis_addr] <= writen_data;
      else if (mem_vis_signal != 2'b00) mem_data <= mem[mem_vis_addr];
    end
  end

  // Bus monitor: every visit must match the next expected byte transaction in order
  always @(negedge clk) begin
    if (rst_n && mem_vis_signal != 2'b00) begin
      if (exp_q.size() == 0) check_eq("bus_extra", 32'(mem_vis_signal), 32'd0);
      else begin
        mon_v = exp_q.pop_front();
        check_eq("bus_addr", 32'(mem_vis_addr), 32'(mon_v.addr));
        check_eq("bus_sig", 32'(mem_vis_signal), 32'(mon_v.sig));
        if (mon_v.sig == 2'b11) check_eq("bus_wdata", 32'(writen_data), 32'(mon_v.wd));
      end
    end
  end

  function automatic int size_n(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [16:0] a, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v |= 32'(ref_mem[17'(a + 17'(k))]) << (8 * k);
    return v;
  endfunction

  task automatic push_visits(input logic [16:0] a, input int n, input logic [1:0] sig,
                             input logic [31:0] wd);
    visit_t v;
    for (int k = 0; k < n; k++) begin
      v.addr = 17'(a + 17'(k));
      v.sig  = sig;
      v.wd   = wd[8*k +: 8];
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (busy !== 1'b0) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One transaction from an idle controller; checks latency, result and done pulse
  task automatic run_txn(input bit is_data, input bit we, input logic [1:0] size,
                         input logic [16:0] addr, input logic [31:0] wdata,
                         input bit drop_early, output logic [31:0] res);
    int n, edges, exp_lat;
    bit got;
    logic [31:0] exp;
    logic [1:0]  sig;
    n   = is_data ? size_n(size) : 4;
    sig = !is_data ? 2'b01 : (we ? 2'b11 : 2'b10);
    wait_idle();
    exp = (is_data && we) ? 32'h0 : ref_read(addr, n);
    push_visits(addr, n, sig, wdata);
    if (is_data && we)
      for (int k = 0; k < n; k++) ref_mem[17'(addr + 17'(k))] = wdata[8*k +: 8];
    if (is_data) begin
      data_req = 1'b1; data_we = we; data_size = size; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    exp_lat = (is_data && we) ? n + 1 : n + 2;
    edges = 0;
    got = 1'b0;
    while (!got && edges < 20) begin
      @(posedge clk); #1; edges++;
      if (drop_early && edges == 2) begin inst_req = 1'b0; data_req = 1'b0; end
      got = is_data ? data_done : inst_done;
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    check_eq("done_seen", 32'(got), 32'd1);
    check_eq("latency", 32'(edges), 32'(exp_lat));
    check_eq("busy_in_done", 32'(busy), 32'd1);
    check_eq("other_done", 32'(is_data ? inst_done : data_done), 32'd0);
    res = is_data ? data_rdata : inst_data;
    if (!(is_data && we)) check_eq(is_data ? "load_data" : "fetch_data", res, exp);
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(is_data ? data_done : inst_done), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
  endtask

  logic [31:0] r, rd, ri, w;
  logic [31:0] exp_d, exp_i;
  logic [7:0]  old2, old3;
  logic [16:0] fa [3];
  int          de, ie, idx;
  int          done_edge [3];

  initial begin
    for (int i = 0; i < 131072; i++) ref_mem[i] = 8'($urandom);
    ref_mem[17'h100] = 8'h13; ref_mem[17'h101] = 8'h00;
    ref_mem[17'h102] = 8'h50; ref_mem[17'h103] = 8'h93;
    init_done = 1'b1;
    #12 rst_n = 1'b1;

    // Reset state
    check_eq("rst_inst_done", 32'(inst_done), 32'd0);
    check_eq("rst_data_done", 32'(data_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_vis_sig", 32'(mem_vis_signal), 32'd0);
    check_eq("rst_vis_addr", 32'(mem_vis_addr), 32'd0);
    check_eq("rst_wr", 32'(writen_data), 32'd0);
    check_eq("rst_inst_data", inst_data, 32'd0);
    check_eq("rst_rdata", data_rdata, 32'd0);
    @(posedge clk); #1;

    // Preloaded fetch
    run_txn(1'b0, 1'b0, 2'b10, 17'h100, 32'h0, 1'b0, r);
    check_eq("fetch_const", r, 32'h93500013);

    // Word store then byte load
    run_txn(1'b1, 1'b1, 2'b10, 17'h200, 32'hDEADBEEF, 1'b0, r);
    check_eq("st_b0", 32'(mem[17'h200]), 32'hEF);
    check_eq("st_b1", 32'(mem[17'h201]), 32'hBE);
    check_eq("st_b2", 32'(mem[17'h202]), 32'hAD);
    check_eq("st_b3", 32'(mem[17'h203]), 32'hDE);
    run_txn(1'b1, 1'b0, 2'b00, 17'h201, 32'h0, 1'b0, r);
    check_eq("ld_byte_const", r, 32'h000000BE);

    // Half store / load across the address wrap
    run_txn(1'b1, 1'b1, 2'b01, 17'h1FFFF, 32'h0000A1B2, 1'b0, r);
    check_eq("wrap_hi", 32'(mem[17'h1FFFF]), 32'hB2);
    check_eq("wrap_lo", 32'(mem[17'h00000]), 32'hA1);
    run_txn(1'b1, 1'b0, 2'b01, 17'h1FFFF, 32'h0, 1'b0, r);
    check_eq("wrap_load_const", r, 32'h0000A1B2);

    // Simultaneous requests: data first, fetch after DONE plus one IDLE edge
    wait_idle();
    exp_d = ref_read(17'h300, 4);
    exp_i = ref_read(17'h100, 4);
    push_visits(17'h300, 4, 2'b10, 32'h0);
    push_visits(17'h100, 4, 2'b01, 32'h0);
    data_req = 1'b1; data_we = 1'b0; data_size = 2'b10; data_addr = 17'h300;
    inst_req = 1'b1; inst_addr = 17'h100;
    de = 0; ie = 0; rd = '0; ri = '0;
    for (int e = 1; e <= 30 && ie == 0; e++) begin
      @(posedge clk); #1;
      if (data_done) begin if (de == 0) de = e; data_req = 1'b0; rd = data_rdata; end
      if (inst_done) begin ie = e; inst_req = 1'b0; ri = inst_data; end
    end
    data_req = 1'b0; inst_req = 1'b0;
    check_eq("arb_data_edge", 32'(de), 32'd6);
    check_eq("arb_inst_edge", 32'(ie), 32'd13);
    check_eq("arb_rdata", rd, exp_d);
    check_eq("arb_inst_data", ri, exp_i);

    // Reset in the middle of a word store after two bytes issued
    wait_idle();
    w = $urandom;
    old2 = ref_mem[17'h402];
    old3 = ref_mem[17'h403];
    push_visits(17'h400, 2, 2'b11, w);
    data_req = 1'b1; data_we = 1'b1; data_size = 2'b10; data_addr = 17'h400; data_wdata = w;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_sig", 32'(mem_vis_signal), 32'd0);
    check_eq("mid_rst_addr", 32'(mem_vis_addr), 32'd0);
    check_eq("mid_rst_wr", 32'(writen_data), 32'd0);
    check_eq("mid_rst_done", 32'(data_done), 32'd0);
    data_req = 1'b0;
    ref_mem[17'h400] = w[7:0];
    ref_mem[17'h401] = w[15:8];
    @(posedge clk); #1;
    check_eq("rst_hold_done", 32'(data_done), 32'd0);
    rst_n = 1'b1;
    check_eq("rst_m400", 32'(mem[17'h400]), 32'(w[7:0]));
    check_eq("rst_m401", 32'(mem[17'h401]), 32'(w[15:8]));
    check_eq("rst_m402", 32'(mem[17'h402]), 32'(old2));
    check_eq("rst_m403", 32'(mem[17'h403]), 32'(old3));
    check_eq("rst_visits_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 2'b10, 17'h400, 32'h0, 1'b0, r);

    // Back-to-back fetches with inst_req held high
    wait_idle();
    fa[0] = 17'h100; fa[1] = 17'h104; fa[2] = 17'h1FFFE;
    for (int i = 0; i < 3; i++) push_visits(fa[i], 4, 2'b01, 32'h0);
    inst_req = 1'b1; inst_addr = fa[0]; idx = 0;
    for (int e = 1; e <= 40 && idx < 3; e++) begin
      @(posedge clk); #1;
      if (inst_done) begin
        done_edge[idx] = e;
        check_eq("b2b_data", inst_data, ref_read(fa[idx], 4));
        idx++;
        if (idx < 3) inst_addr = fa[idx];
        else inst_req = 1'b0;
      end
    end
    inst_req = 1'b0;
    check_eq("b2b_count", 32'(idx), 32'd3);
    for (int i = 0; i < 3; i++) check_eq("b2b_edge", 32'(done_edge[i]), 32'(6 + 7 * i));

    // Randomized mix of fetches, loads and stores
    for (int t = 0; t < 60; t++) begin
      int kind;
      logic [1:0]  sz;
      logic [16:0] a;
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       a = 17'(17'h1FFFC + 17'($urandom_range(0, 3)));
        1:       a = 17'(17'h500 + 17'($urandom_range(0, 15)));
        default: a = 17'($urandom);
      endcase
      run_txn(kind != 0, kind == 2, sz, a, $urandom, $urandom_range(0, 3) == 0, r);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    check_eq("visits_left", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the CPU fetch/load-store units and the byte-wide main memory.
- Arbitrates one instruction port and one data port.
- Splits each byte, half or word access into sequential byte transactions on the main-memory bus (byte address, 2-bit visit signal, one cycle registered read latency).
- Reassembles read bytes little-endian and pulses a done strobe to the requester.

Parameters:
- ADDR_WIDTH, 17, byte-address width of main memory.
- LEN, 32, CPU word width.
- BYTE_SIZE, 8, memory data width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request, level, held until inst_done
- inst_addr  in  ADDR_WIDTH  fetch byte address
- inst_data  out  LEN  fetched word, valid while inst_done=1
- inst_done  out  1  one-cycle completion pulse
- data_req  in  1  load/store request, level, held until data_done
- data_we  in  1  1=store, 0=load
- data_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- data_addr  in  ADDR_WIDTH  load/store byte address
- data_wdata  in  LEN  store data, low bytes used
- data_rdata  out  LEN  zero-extended load data, valid while data_done=1
- data_done  out  1  one-cycle completion pulse
- busy  out  1  1 in any state except IDLE
- mem_data  in  BYTE_SIZE  byte returned by memory, valid the cycle after its read edge
- mem_vis_addr  out  ADDR_WIDTH  memory byte address
- mem_vis_signal  out  2  IDLE=00, READ_INST=01, READ_DATA=10, WRITE=11
- writen_data  out  BYTE_SIZE  store byte

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; mem_vis_signal=IDLE.
  - Any in-flight request is abandoned with no done pulse.
  - Partial writes already issued stay in memory.
- Memory bus outputs are registered. Memory samples them on the following edge.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On an edge with data_req=1, accept the data request. Data has priority over instruction.
  - Otherwise, on an edge with inst_req=1, accept the fetch.
  - Latch op, address and byte count n. Fetch n=4; data n=1/2/4 per data_size.
  - At the accept edge E0, drive byte 0 and go to ISSUE.
- ISSUE: at edge Ek (k=1..n-1) drive address base+k, wrapping mod 2^ADDR_WIDTH. The signal is READ_INST, READ_DATA or WRITE.
  - For WRITE, writen_data = wdata[8k+7:8k].
- Last byte issued:
  - Next edge drives mem_vis_signal=IDLE.
  - A write goes to DONE at edge En; the memory commits byte n-1 at En.
  - A read goes to DRAIN.
- Read capture: byte k is captured from mem_data at edge E(k+2) into bits [8k+7:8k]. Unused upper bytes are 0.
  - The last capture happens at E(n+1); at that edge go to DONE.
- DONE:
  - Exactly one cycle with the corresponding done=1 and rdata/inst_data valid.
  - Next edge returns to IDLE. No request is accepted during DONE.
  - Data outputs hold their value until the next capture; done is 0 outside DONE.
- Latency, accept edge to done-high cycle:
  - word read: 6 cycles; half read: 4; byte read: 3.
  - word write: 5 cycles; half write: 3; byte write: 2.
- Both requests present in IDLE: data is served first. The fetch is served on the first IDLE edge after data's DONE.
- A requester dropping req mid-transaction has no effect; the transaction completes.
- No alignment check; misaligned and wrap-around (0x1FFFF→0x00000) accesses are legal.
- mem_vis_signal is IDLE whenever state is IDLE, DONE, or DRAIN after the last issue.

Decomposition:
- Shared defines file:
  - MEM_IDLE/READ_INST/READ_DATA/WRITE visit-signal encodings.
  - SIZE_BYTE/HALF/WORD codes.
  - Controller state encodings.
- One natural sub-module: mem_arb, a combinational fixed-priority select. Inputs are both request sets; outputs are grant, op, base address and byte count.

Test Plan:
- Preload bytes 0x100..0x103 = 13 00 50 93; inst_req at 0x100 → inst_done 6 cycles after accept, inst_data=0x93500013. Bus shows addresses 0x100..0x103 with READ_INST on consecutive cycles.
- Store word 0xDEADBEEF at 0x200, then load byte at 0x201 → bytes 0x200..0x203 = EF BE AD DE; data_rdata=0x000000BE; store done 5 cycles, load done 3 cycles after accept.
- Half store 0xA1B2 at 0x1FFFF → byte 0x1FFFF=B2, byte 0x00000=A1 (wrap). Half load at 0x1FFFF returns 0x0000A1B2.
- inst_req and data_req (load word at 0x300) asserted same cycle → data served first; inst_done asserts only after data_done plus one IDLE cycle. No overlapping bus activity.
- Assert rst_n=0 in the middle of a word store at 0x400, after 2 bytes are issued → outputs 0 immediately, no data_done; bytes 0x400/0x401 written, 0x402/0x403 unchanged. Next request completes normally.
- Back-to-back fetches with inst_req held high → exactly one DONE cycle plus one IDLE cycle between transactions. inst_done is a single-cycle pulse each time.
